snake_renderer: RTL and testbench

//   Pixel-stage renderer fed by the 640x480@60Hz timing generator.
//   - Maps each (pixel_x, pixel_y) to a board cell and reads the cell code

---
 rtl/snake_renderer_pkg.sv | 38 +++
 rtl/vga_delay_line.sv | 32 +++
 rtl/snake_renderer.sv | 148 ++++++++++++++
 tb/tb_snake_renderer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_renderer_pkg.sv
// Shared definitions for the snake renderer: cell codes, colour levels,
// board geometry defaults and the 640x480 VGA timing constants.
package snake_renderer_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_BODY  = 2'd1,
        CELL_HEAD  = 2'd2,
        CELL_FOOD  = 2'd3
    } cell_t;

    localparam logic [2:0] COL_OFF  = 3'd0;
    localparam logic [2:0] COL_FULL = 3'd7;

    localparam int DEF_CELL_SHIFT = 5;
    localparam int DEF_GRID_W     = 20;
    localparam int DEF_GRID_H     = 15;
    localparam int DEF_BLINK_BIT  = 4;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = 800;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = 525;

    // Board index row*20 + col, with the multiply by 20 built from shifts.
    function automatic logic [8:0] grid_addr(input logic [3:0] row, input logic [4:0] col);
        logic [8:0] r9;
        r9 = {5'd0, row};
        return (r9 << 4) + (r9 << 2) + {4'd0, col};
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// N-stage shift register carrying sync/video_on bits alongside the pixel
// pipeline; each bit has its own reset value so syncs idle high.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift the input through DEPTH registers, all loaded with RESET_VAL on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RESET_VAL;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/snake_renderer.sv
// Pixel-stage renderer: maps the pixel to a board cell, reads its code and
// produces registered RGB three clocks after the inputs, with matching syncs
// and a once-per-frame tick for the game logic.
module snake_renderer
    import snake_renderer_pkg::*;
#(
    parameter int CELL_SHIFT = DEF_CELL_SHIFT,
    parameter int GRID_W     = DEF_GRID_W,
    parameter int GRID_H     = DEF_GRID_H,
    parameter int BLINK_BIT  = DEF_BLINK_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       video_on_in,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic [8:0] cell_addr,
    input  logic [1:0] cell_data,
    input  logic       game_over,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [2:0] red,
    output logic [2:0] grn,
    output logic [2:0] blu,
    output logic       frame_tick
);

    logic [9:0]            col_full;
    logic [9:0]            row_full;
    logic                  in_grid;
    logic [CELL_SHIFT-1:0] ox1, oy1, ox2, oy2;
    cell_t                 cell2;
    logic                  von2;
    logic [1:0]            sync_out;
    logic [2:0]            red_n, grn_n, blu_n;
    logic                  blink;
    logic                  vs_prev;
    logic                  fall;
    logic [5:0]            frame_cnt;

    assign col_full = pixel_x >> CELL_SHIFT;
    assign row_full = pixel_y >> CELL_SHIFT;
    assign in_grid  = (col_full < 10'(GRID_W)) && (row_full < 10'(GRID_H));

    // Stage 1: board address and in-cell offsets; off-board pixels read cell 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_addr <= '0;
            ox1       <= '0;
            oy1       <= '0;
        end else begin
            cell_addr <= in_grid ? grid_addr(row_full[3:0], col_full[4:0]) : 9'd0;
            ox1       <= pixel_x[CELL_SHIFT-1:0];
            oy1       <= pixel_y[CELL_SHIFT-1:0];
        end
    end

    // Stage 2: capture the cell code returned for the stage-1 address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell2 <= CELL_EMPTY;
            ox2   <= '0;
            oy2   <= '0;
        end else begin
            cell2 <= cell_t'(cell_data);
            ox2   <= ox1;
            oy2   <= oy1;
        end
    end

    vga_delay_line #(
        .WIDTH     (2),
        .DEPTH     (3),
        .RESET_VAL (2'b11)
    ) u_sync_dly (
        .clk  (clk),
        .rst  (rst),
        .din  ({hsync_in, vsync_in}),
        .dout (sync_out)
    );

    vga_delay_line #(
        .WIDTH     (1),
        .DEPTH     (2),
        .RESET_VAL (1'b0)
    ) u_von_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (video_on_in),
        .dout (von2)
    );

    assign hsync_out = sync_out[1];
    assign vsync_out = sync_out[0];
    assign blink     = game_over & frame_cnt[BLINK_BIT];

    // Colour decode: row/column 0 of each cell is a black gap; game over blinks snake red.
    always_comb begin
        red_n = COL_OFF;
        grn_n = COL_OFF;
        blu_n = COL_OFF;
        if (von2 && (ox2 != '0) && (oy2 != '0)) begin
            case (cell2)
                CELL_BODY: begin
                    if (blink) red_n = COL_FULL;
                    else       grn_n = COL_FULL;
                end
                CELL_HEAD: begin
                    red_n = COL_FULL;
                    if (!blink) grn_n = COL_FULL;
                end
                CELL_FOOD: red_n = COL_FULL;
                default: ;
            endcase
        end
    end

    // Stage 3: register the colour so it lines up with the delayed syncs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red <= COL_OFF;
            grn <= COL_OFF;
            blu <= COL_OFF;
        end else begin
            red <= red_n;
            grn <= grn_n;
            blu <= blu_n;
        end
    end

    assign fall = vs_prev & ~vsync_in;

    // Frame pacing: tick and count on each vsync falling edge; vs_prev clears so release never ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev    <= 1'b0;
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            vs_prev    <= vsync_in;
            frame_tick <= fall;
            if (fall) frame_cnt <= frame_cnt + 6'd1;
        end
    end

endmodule

// File: tb/tb_snake_renderer.sv
// Directed bench for snake_renderer: address map, colour decode, pipeline
// latency, sync delay, frame ticks, game-over blink and async reset.
module tb_snake_renderer;

    logic       clk;
    logic       rst;
    logic       hsync_in;
    logic       vsync_in;
    logic       video_on_in;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [8:0] cell_addr;
    logic [1:0] cell_data;
    logic       game_over;
    logic       hsync_out;
    logic       vsync_out;
    logic [2:0] red, grn, blu;
    logic       frame_tick;
    logic [8:0] rgb;

    logic [1:0] ram [0:299];

    int errors = 0;
    int checks = 0;

    snake_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .video_on_in (video_on_in),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .cell_addr   (cell_addr),
        .cell_data   (cell_data),
        .game_over   (game_over),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .red         (red),
        .grn         (grn),
        .blu         (blu),
        .frame_tick  (frame_tick)
    );

    assign rgb = {red, grn, blu};

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Board RAM model: data for the current address is ready by the next edge.
    always_comb begin
        cell_data = 2'd0;
        if (cell_addr < 9'd300) cell_data = ram[cell_addr];
    end

    task automatic applyStimulus(input int x, input int y, input logic von,
                                 input logic hs, input logic vs);
        pixel_x     = 10'(x);
        pixel_y     = 10'(y);
        video_on_in = von;
        hsync_in    = hs;
        vsync_in    = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    localparam logic [8:0] RGB_BLACK  = {3'd0, 3'd0, 3'd0};
    localparam logic [8:0] RGB_YELLOW = {3'd7, 3'd7, 3'd0};
    localparam logic [8:0] RGB_GREEN  = {3'd0, 3'd7, 3'd0};
    localparam logic [8:0] RGB_RED    = {3'd7, 3'd0, 3'd0};

    initial begin
        int first_low;
        int low_cnt;
        int tick_high;
        int tick_pulses;
        logic prev_tick;

        for (int i = 0; i < 300; i++) ram[i] = 2'd0;
        ram[21] = 2'd2;
        ram[22] = 2'd3;
        ram[38] = 2'd1;

        rst         = 1'b1;
        hsync_in    = 1'b1;
        vsync_in    = 1'b1;
        video_on_in = 1'b0;
        pixel_x     = '0;
        pixel_y     = '0;
        game_over   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rgb",   16'(rgb),        16'(RGB_BLACK));
        checkOutput("reset_hsync", 16'(hsync_out),  16'd1);
        checkOutput("reset_vsync", 16'(vsync_out),  16'd1);
        checkOutput("reset_tick",  16'(frame_tick), 16'd0);
        checkOutput("reset_addr",  16'(cell_addr),  16'd0);
        #4 rst = 1'b0;

        applyStimulus(639, 479, 1'b1, 1'b1, 1'b1);
        checkOutput("addr_639_479", 16'(cell_addr), 16'd299);
        applyStimulus(31, 31, 1'b1, 1'b1, 1'b1);
        checkOutput("addr_31_31", 16'(cell_addr), 16'd0);
        applyStimulus(0, 32, 1'b1, 1'b1, 1'b1);
        checkOutput("addr_0_32", 16'(cell_addr), 16'd20);
        applyStimulus(32, 0, 1'b1, 1'b1, 1'b1);
        checkOutput("addr_32_0", 16'(cell_addr), 16'd1);
        applyStimulus(700, 40, 1'b0, 1'b1, 1'b1);
        checkOutput("addr_offgrid", 16'(cell_addr), 16'd0);

        applyStimulus(40, 40, 1'b1, 1'b1, 1'b1);
        applyStimulus(32, 40, 1'b1, 1'b1, 1'b1);
        applyStimulus(200, 200, 1'b1, 1'b1, 1'b1);
        checkOutput("head_40_40", 16'(rgb), 16'(RGB_YELLOW));
        applyStimulus(40, 40, 1'b0, 1'b1, 1'b1);
        checkOutput("gap_32_40", 16'(rgb), 16'(RGB_BLACK));
        applyStimulus(72, 40, 1'b1, 1'b1, 1'b1);
        checkOutput("empty_cell", 16'(rgb), 16'(RGB_BLACK));
        applyStimulus(600, 40, 1'b1, 1'b1, 1'b1);
        checkOutput("video_off", 16'(rgb), 16'(RGB_BLACK));
        applyStimulus(600, 40, 1'b1, 1'b1, 1'b1);
        checkOutput("food", 16'(rgb), 16'(RGB_RED));
        applyStimulus(640, 40, 1'b0, 1'b1, 1'b1);
        checkOutput("body_a", 16'(rgb), 16'(RGB_GREEN));
        applyStimulus(641, 40, 1'b0, 1'b1, 1'b1);
        checkOutput("line_end_2clk", 16'(rgb), 16'(RGB_GREEN));
        applyStimulus(642, 40, 1'b0, 1'b1, 1'b1);
        checkOutput("line_end_3clk", 16'(rgb), 16'(RGB_BLACK));

        first_low = -1;
        low_cnt   = 0;
        for (int n = 1; n <= 104; n++) begin
            applyStimulus(700, 40, 1'b0, (n <= 96) ? 1'b0 : 1'b1, 1'b1);
            if (hsync_out == 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = n;
            end
        end
        checkOutput("hsync_start", 16'(first_low), 16'd3);
        checkOutput("hsync_width", 16'(low_cnt),   16'd96);

        tick_high   = 0;
        tick_pulses = 0;
        prev_tick   = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 6; k++) begin
                applyStimulus(700, 500, 1'b0, 1'b1, (k < 3) ? 1'b0 : 1'b1);
                if (frame_tick) tick_high++;
                if (frame_tick && !prev_tick) tick_pulses++;
                prev_tick = frame_tick;
            end
        end
        checkOutput("tick_pulses", 16'(tick_pulses),   16'd3);
        checkOutput("tick_width",  16'(tick_high),     16'd3);
        checkOutput("frame_cnt_3", 16'(dut.frame_cnt), 16'd3);

        applyStimulus(700, 500, 1'b0, 1'b1, 1'b0);
        #4 rst = 1'b1;
        @(posedge clk);
        #5 rst = 1'b0;
        tick_high = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(700, 500, 1'b0, 1'b1, 1'b0);
            if (frame_tick) tick_high++;
        end
        checkOutput("no_tick_after_rst", 16'(tick_high),     16'd0);
        checkOutput("frame_cnt_rst",     16'(dut.frame_cnt), 16'd0);

        game_over = 1'b1;
        repeat (3) applyStimulus(600, 40, 1'b1, 1'b1, 1'b1);
        checkOutput("go_body_cnt0", 16'(rgb), 16'(RGB_GREEN));
        repeat (3) applyStimulus(72, 40, 1'b1, 1'b1, 1'b1);
        checkOutput("go_food_cnt0", 16'(rgb), 16'(RGB_RED));
        for (int f = 0; f < 16; f++) begin
            applyStimulus(700, 500, 1'b0, 1'b1, 1'b0);
            applyStimulus(700, 500, 1'b0, 1'b1, 1'b1);
        end
        checkOutput("frame_cnt_16", 16'(dut.frame_cnt), 16'd16);
        repeat (3) applyStimulus(600, 40, 1'b1, 1'b1, 1'b1);
        checkOutput("go_body_cnt16", 16'(rgb), 16'(RGB_RED));
        repeat (3) applyStimulus(40, 40, 1'b1, 1'b1, 1'b1);
        checkOutput("go_head_cnt16", 16'(rgb), 16'(RGB_RED));
        repeat (3) applyStimulus(72, 40, 1'b1, 1'b1, 1'b1);
        checkOutput("go_food_cnt16", 16'(rgb), 16'(RGB_RED));
        game_over = 1'b0;
        repeat (3) applyStimulus(600, 40, 1'b1, 1'b1, 1'b1);
        checkOutput("body_no_go", 16'(rgb), 16'(RGB_GREEN));
        game_over = 1'b1;
        applyStimulus(600, 40, 1'b1, 1'b1, 1'b1);
        checkOutput("go_no_delay", 16'(rgb), 16'(RGB_RED));
        game_over = 1'b0;

        repeat (3) applyStimulus(40, 40, 1'b1, 1'b0, 1'b1);
        checkOutput("pre_rst_rgb",   16'(rgb),       16'(RGB_YELLOW));
        checkOutput("pre_rst_hsync", 16'(hsync_out), 16'd0);
        #4 rst = 1'b1;
        #1;
        checkOutput("async_rst_rgb",   16'(rgb),       16'(RGB_BLACK));
        checkOutput("async_rst_hsync", 16'(hsync_out), 16'd1);
        checkOutput("async_rst_addr",  16'(cell_addr), 16'd0);
        @(posedge clk);
        #5 rst = 1'b0;
        applyStimulus(40, 40, 1'b1, 1'b0, 1'b1);
        checkOutput("rel_clk1_rgb",   16'(rgb),       16'(RGB_BLACK));
        checkOutput("rel_clk1_hsync", 16'(hsync_out), 16'd1);
        applyStimulus(40, 40, 1'b1, 1'b0, 1'b1);
        checkOutput("rel_clk2_rgb",   16'(rgb),       16'(RGB_BLACK));
        checkOutput("rel_clk2_hsync", 16'(hsync_out), 16'd1);
        applyStimulus(40, 40, 1'b1, 1'b0, 1'b1);
        checkOutput("rel_clk3_rgb",   16'(rgb),       16'(RGB_YELLOW));
        checkOutput("rel_clk3_hsync", 16'(hsync_out), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
